// File: rtl/branch_seq_pkg.sv
// Shared definitions for the conditional-jump sequencer:
// condition codes, flag bit positions and FSM state encoding.
package branch_seq_pkg;

  localparam int BYTE_W = 8;

  localparam int F_N = 0;
  localparam int F_Z = 1;
  localparam int F_C = 2;
  localparam int F_V = 3;

  typedef enum logic [3:0] {
    CC_AL = 4'd0,
    CC_EQ = 4'd1,
    CC_NE = 4'd2,
    CC_CS = 4'd3,
    CC_CC = 4'd4,
    CC_MI = 4'd5,
    CC_PL = 4'd6,
    CC_VS = 4'd7,
    CC_VC = 4'd8,
    CC_HI = 4'd9,
    CC_LS = 4'd10,
    CC_GE = 4'd11,
    CC_LT = 4'd12,
    CC_GT = 4'd13,
    CC_LE = 4'd14,
    CC_NV = 4'd15
  } cc_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH_LO = 2'd1,
    S_FETCH_HI = 2'd2,
    S_COMMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/branch_seq_if.sv
// Operand-fetch handshake between the jump sequencer
// and memory: request out, byte plus ready back.
interface branch_seq_if;
  import branch_seq_pkg::*;

  logic              rd_req;
  logic [BYTE_W-1:0] bus;
  logic              rdy;

  modport master (
    output rd_req,
    input  bus,
    input  rdy
  );

  modport slave (
    input  rd_req,
    output bus,
    output rdy
  );

endinterface

// File: rtl/branch_seq_cond.sv
// Combinational condition evaluator: maps a 4-bit
// condition code and the N/Z/C/V flags to a decision.
module cond_eval
  import branch_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] fin,
  output logic       true
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = fin[F_N];
  assign z = fin[F_Z];
  assign c = fin[F_C];
  assign v = fin[F_V];

  always_comb begin
    true = 1'b0;
    unique case (cc_t'(cond))
      CC_AL: true = 1'b1;
      CC_EQ: true = z;
      CC_NE: true = ~z;
      CC_CS: true = c;
      CC_CC: true = ~c;
      CC_MI: true = n;
      CC_PL: true = ~n;
      CC_VS: true = v;
      CC_VC: true = ~v;
      CC_HI: true = c & ~z;
      CC_LS: true = ~c | z;
      CC_GE: true = (n == v);
      CC_LT: true = (n != v);
      CC_GT: true = ~z & (n == v);
      CC_LE: true = z | (n != v);
      CC_NV: true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// Conditional-jump sequencer: decides on start, fetches a
// two-byte target when taken, then strobes load or skip.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cond,
  input  logic [3:0]        fin,
  branch_seq_if.master      mem,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              pc_load,
  output logic              pc_skip,
  output logic              busy,
  output logic              taken
);

  state_t state;
  state_t state_nx;

  logic cond_true;
  logic accept;
  logic lo_we;
  logic hi_we;
  logic rd_req;

  cond_eval u_cond (
    .cond (cond),
    .fin  (fin),
    .true (cond_true)
  );

  assign accept     = start && (state == S_IDLE);
  assign mem.rd_req = rd_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_req   = 1'b0;
    pc_load  = 1'b0;
    pc_skip  = 1'b0;
    busy     = 1'b1;
    lo_we    = 1'b0;
    hi_we    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = cond_true ? S_FETCH_LO
                               : S_COMMIT;
        end
      end
      S_FETCH_LO: begin
        rd_req = 1'b1;
        if (mem.rdy) begin
          lo_we    = 1'b1;
          state_nx = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        rd_req = 1'b1;
        if (mem.rdy) begin
          hi_we    = 1'b1;
          state_nx = S_COMMIT;
        end
      end
      S_COMMIT: begin
        pc_load  = taken;
        pc_skip  = ~taken;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Flags are only looked at on the accepting edge;
  // later flag reloads cannot alter the decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_addr <= '0;
      taken   <= 1'b0;
    end else begin
      if (accept) taken <= cond_true;
      if (lo_we) begin
        pc_addr[BYTE_W-1:0] <= mem.bus;
      end
      if (hi_we) begin
        pc_addr[ADDR_W-1:BYTE_W] <=
          mem.bus[ADDR_W-BYTE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed and random
// jumps scored against a flag-rule reference model.
module tb_branch_seq;
  import branch_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cond = 4'd0;
  logic [3:0]  fin = 4'd0;
  logic [15:0] pc_addr;
  logic        pc_load;
  logic        pc_skip;
  logic        busy;
  logic        taken;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_addr = 16'd0;

  branch_seq_if bif();

  branch_seq #(.ADDR_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cond    (cond),
    .fin     (fin),
    .mem     (bif),
    .pc_addr (pc_addr),
    .pc_load (pc_load),
    .pc_skip (pc_skip),
    .busy    (busy),
    .taken   (taken)
  );

  always #5 clk = ~clk;

  function automatic bit model_taken(
    input logic [3:0] c,
    input logic [3:0] f
  );
    bit n;
    bit z;
    bit cy;
    bit v;
    n  = f[0];
    z  = f[1];
    cy = f[2];
    v  = f[3];
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return cy;
      4'd4:  return !cy;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return cy && !z;
      4'd10: return !cy || z;
      4'd11: return n == v;
      4'd12: return n != v;
      4'd13: return !z && (n == v);
      4'd14: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // One complete jump; noisy re-asserts start and scrambles
  // cond/fin while busy, rel releases reset with the start.
  task automatic do_jump(
    input string      nm,
    input logic [3:0] c,
    input logic [3:0] f,
    input logic [7:0] lo,
    input logic [7:0] hi,
    input int         dlo,
    input int         dhi,
    input bit         noisy,
    input bit         rel
  );
    bit et;
    bit done;
    bit gl;
    bit gs;
    int cyc;
    int rdc;
    int wt;
    int nb;
    int elat;
    et   = model_taken(c, f);
    elat = et ? dlo + dhi + 2 : 0;
    done = 1'b0;
    gl   = 1'b0;
    gs   = 1'b0;
    @(negedge clk);
    if (rel) reset = 1'b0;
    start   = 1'b1;
    cond    = c;
    fin     = f;
    bif.rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_accept: got %b want 1",
               nm, busy);
    end
    start = noisy;
    if (noisy) begin
      fin  = ~f;
      cond = 4'($urandom);
    end
    cyc = 0;
    rdc = 0;
    wt  = dlo;
    nb  = 0;
    while (!done && cyc < 64) begin
      if (pc_load === 1'b1 || pc_skip === 1'b1) begin
        done = 1'b1;
        gl   = pc_load;
        gs   = pc_skip;
      end else begin
        if (bif.rd_req === 1'b1) begin
          rdc++;
          if (wt > 0) begin
            bif.rdy = 1'b0;
            bif.bus = 8'($urandom);
            wt--;
          end else begin
            bif.rdy = 1'b1;
            bif.bus = (nb == 0) ? lo : hi;
            nb++;
            wt = dhi;
          end
        end else begin
          bif.rdy = 1'b0;
          bif.bus = 8'($urandom);
        end
        @(negedge clk);
        cyc++;
        if (noisy) begin
          start = 1'($urandom);
          fin   = 4'($urandom);
          cond  = 4'($urandom);
        end
      end
    end
    bif.rdy = 1'b0;
    start   = 1'b0;
    if (et) exp_addr = {hi, lo};
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: no strobe in %0d cycles",
               nm, cyc);
    end
    checks++;
    if (gl !== et || gs !== !et) begin
      failures++;
      $display("FAIL %s strobe: got load=%b skip=%b want load=%b skip=%b",
               nm, gl, gs, et, !et);
    end
    checks++;
    if (cyc != elat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d",
               nm, cyc, elat);
    end
    checks++;
    if (rdc != elat) begin
      failures++;
      $display("FAIL %s rd_req_cycles: got %0d want %0d",
               nm, rdc, elat);
    end
    checks++;
    if (pc_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s pc_addr: got %h want %h",
               nm, pc_addr, exp_addr);
    end
    checks++;
    if (taken !== et) begin
      failures++;
      $display("FAIL %s taken: got %b want %b",
               nm, taken, et);
    end
    @(negedge clk);
    checks++;
    if (pc_load !== 1'b0 || pc_skip !== 1'b0 ||
        busy !== 1'b0 || bif.rd_req !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after: got load=%b skip=%b busy=%b rd=%b want 0000",
               nm, pc_load, pc_skip, busy, bif.rd_req);
    end
    checks++;
    if (taken !== et || pc_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s hold_after: got taken=%b addr=%h want %b %h",
               nm, taken, pc_addr, et, exp_addr);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (pc_addr !== 16'd0 || taken !== 1'b0 ||
        pc_load !== 1'b0 || pc_skip !== 1'b0 ||
        busy !== 1'b0 || bif.rd_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got addr=%h tk=%b ld=%b sk=%b bz=%b rd=%b want all 0",
               pc_addr, taken, pc_load, pc_skip, busy, bif.rd_req);
    end
    do_jump("first_after_reset", CC_AL, 4'h0,
            8'hA5, 8'h5A, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_directed();
    do_jump("eq_taken", CC_EQ, 4'b0010,
            8'h34, 8'h12, 0, 0, 1'b0, 1'b0);
    do_jump("eq_not_taken", CC_EQ, 4'b0000,
            8'hEE, 8'hDD, 0, 0, 1'b0, 1'b0);
    do_jump("ge_not_taken", CC_GE, 4'b1000,
            8'h11, 8'h22, 0, 0, 1'b0, 1'b0);
    do_jump("ge_taken", CC_GE, 4'b1001,
            8'h78, 8'h56, 0, 0, 1'b0, 1'b0);
    do_jump("never", CC_NV, 4'($urandom),
            8'h99, 8'h88, 0, 0, 1'b0, 1'b0);
    do_jump("always", CC_AL, 4'($urandom),
            8'hCD, 8'hAB, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rdy_stall();
    do_jump("stall_lo", CC_CS, 4'b0100,
            8'h0F, 8'hF0, 3, 0, 1'b0, 1'b0);
    do_jump("stall_hi", CC_NE, 4'b0000,
            8'h3C, 8'hC3, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midfetch();
    @(negedge clk);
    start = 1'b1;
    cond  = CC_AL;
    fin   = 4'($urandom);
    @(negedge clk);
    start   = 1'b0;
    bif.rdy = 1'b1;
    bif.bus = 8'h77;
    @(negedge clk);
    bif.rdy = 1'b0;
    checks++;
    if (bif.rd_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_prefetch: got rd=%b want 1",
               bif.rd_req);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (pc_addr !== 16'd0 || taken !== 1'b0 ||
        pc_load !== 1'b0 || pc_skip !== 1'b0 ||
        busy !== 1'b0 || bif.rd_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_fetch: got addr=%h tk=%b ld=%b sk=%b bz=%b rd=%b want all 0",
               pc_addr, taken, pc_load, pc_skip, busy, bif.rd_req);
    end
    exp_addr = 16'd0;
    @(negedge clk);
    do_jump("after_mid_reset", CC_MI, 4'b0001,
            8'h21, 8'h43, 1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_jump("busy_noise_taken", CC_GT, 4'b0000,
            8'h5E, 8'hE5, 1, 1, 1'b1, 1'b0);
    do_jump("busy_noise_not", CC_LE, 4'b0000,
            8'h01, 8'h02, 0, 0, 1'b1, 1'b0);
    do_jump("busy_noise_hi", CC_HI, 4'b0100,
            8'hB0, 8'h0B, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_jump($sformatf("rand%0d", i),
              4'($urandom), 4'($urandom),
              8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              1'($urandom), 1'b0);
    end
  endtask

  initial begin
    bif.rdy = 1'b0;
    bif.bus = 8'h00;
    test_reset();
    test_directed();
    test_rdy_stall();
    test_reset_midfetch();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning jump-target width in bits, fixed at 2 bus bytes.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to execute a conditional jump.
REQ-005 SHALL have port cond  input  4  condition code, sampled with start.
REQ-006 SHALL have port fin  input  4  flags from the flags register: bit0 N, bit1 Z, bit2 C, bit3 V.
REQ-007 SHALL have port bus  input  8  operand byte from memory, valid when rdy=1.
REQ-008 SHALL have port rdy  input  1  memory has the requested operand byte on bus.
REQ-009 SHALL have port rd_req  output  1  operand byte requested.
REQ-010 SHALL have port pc_addr  output  ADDR_W  assembled jump target {hi,lo}.
REQ-011 SHALL have port pc_load  output  1  one-cycle strobe: PC loads pc_addr.
REQ-012 SHALL have port pc_skip  output  1  one-cycle strobe: PC advances by 2 past the unused operand.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port taken  output  1  registered decision of the last jump, held until the next accepted start.

Function
REQ-015 SHALL implement states IDLE, FETCH_LO, FETCH_HI, COMMIT.
REQ-016 SHALL accept start only in IDLE; start while busy is ignored with no effect on state or outputs.
REQ-017 SHALL sample cond and fin on the accepting edge, evaluate the condition, and register the result into taken.
REQ-018 SHALL evaluate codes: 0 always, 1 Z, 2 ~Z, 3 C, 4 ~C, 5 N, 6 ~N, 7 V, 8 ~V, 9 C&~Z, 10 ~C|Z, 11 N==V, 12 N!=V, 13 ~Z&(N==V), 14 Z|(N!=V), 15 never.
REQ-019 SHALL go IDLE->FETCH_LO when the condition is true, and IDLE->COMMIT when it is false, without fetching operands.
REQ-020 SHALL assert rd_req combinationally in FETCH_LO and FETCH_HI only.
REQ-021 SHALL, in FETCH_LO with rdy=1, capture bus into pc_addr[7:0] and go to FETCH_HI; with rdy=0, hold state indefinitely.
REQ-022 SHALL, in FETCH_HI with rdy=1, capture bus into pc_addr[15:8] and go to COMMIT; with rdy=0, hold state.
REQ-023 SHALL, in COMMIT, assert pc_load=taken and pc_skip=~taken for exactly one cycle, then return to IDLE.
REQ-024 SHALL never assert pc_load and pc_skip together.
REQ-025 SHALL leave pc_addr unchanged on a not-taken jump.
REQ-026 SHALL, with rdy held high, deliver pc_load on the 3rd edge after acceptance when taken, and pc_skip on the 1st edge after acceptance when not taken.
REQ-027 SHALL ignore fin changes after acceptance, including any flags reload during the fetch.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-fetch, immediately force state IDLE, pc_addr=0, taken=0, pc_load=0, pc_skip=0, rd_req=0, busy=0.
REQ-029 SHALL accept a start on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL keep the condition-code constants and the state encoding in a shared package used by the decoder and the bench.
REQ-031 SHALL place condition evaluation in one combinational sub-module, cond_eval (cond, fin -> true).

Verification
REQ-032 SHALL cover: cond=1, fin=4'b0010, start, rdy=1, bus 0x34 then 0x12 -> rd_req for 2 cycles, then pc_load=1 with pc_addr=0x1234 and taken=1.
REQ-033 SHALL cover: cond=1, fin=4'b0000, start -> next cycle pc_skip=1, rd_req never asserted, pc_addr unchanged, taken=0.
REQ-034 SHALL cover: cond=11 with fin V=1, N=0 (not taken) and fin V=1, N=1 (taken); also cond=15 -> always pc_skip, cond=0 -> always pc_load.
REQ-035 SHALL cover: taken jump with rdy low 3 cycles in FETCH_LO -> FETCH_LO held, bus ignored until rdy=1, final pc_addr correct.
REQ-036 SHALL cover: reset pulse in FETCH_HI -> all outputs 0 immediately; a fresh start after release completes normally.
REQ-037 SHALL cover: start asserted while busy and fin toggled mid-fetch -> neither affects the in-flight jump outcome.
